// File: rtl/sram_ctrl.sv
// Async SRAM controller behind a Wishbone B4 pipelined port; each strobe phase length is a parameter in clocks.
// Ack rises RD_CYCLES+RD_HOLD_CYCLES (read) or WR_SETUP+WR_PULSE+WR_HOLD (write) edges after accept, +TURN_CYCLES if queued behind a direction change; stall is low only in IDLE and on the last hold clock.
module sram_ctrl #(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH      = 17,
    parameter int RD_CYCLES       = 5,
    parameter int RD_HOLD_CYCLES  = 2,
    parameter int WR_SETUP_CYCLES = 2,
    parameter int WR_PULSE_CYCLES = 5,
    parameter int WR_HOLD_CYCLES  = 2,
    parameter int TURN_CYCLES     = 2
) (
    input  logic                  wb_clock_i,
    input  logic                  wb_reset_ni,
    input  logic [ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic                  wb_we_i,
    input  logic                  wb_cycle_i,
    input  logic                  wb_strobe_i,
    output logic                  wb_stall_o,
    output logic                  wb_ack_o,
    output logic                  ram_oe_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  ram_data_oe
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_PHASE = max2(max2(max2(RD_CYCLES, RD_HOLD_CYCLES),
                                         max2(WR_SETUP_CYCLES, WR_PULSE_CYCLES)),
                                    max2(WR_HOLD_CYCLES, TURN_CYCLES));
    localparam int CW = $clog2(MAX_PHASE) + 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        RD_HOLD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        TURN
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic                  last;
    logic                  hold_last;
    logic                  accept;
    logic                  load_bus;
    logic                  load_pend;
    logic                  store_pend;
    logic                  abort;
    logic                  pend_vld;
    logic                  pend_we;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [DATA_WIDTH-1:0] pend_dat;

    // Counter holds clocks remaining in the current phase; zero marks its last clock.
    function automatic logic [CW-1:0] phase_len(input state_t s);
        case (s)
            RD_ACC:   return CW'(RD_CYCLES - 1);
            RD_HOLD:  return CW'(RD_HOLD_CYCLES - 1);
            WR_SETUP: return CW'(WR_SETUP_CYCLES - 1);
            WR_PULSE: return CW'(WR_PULSE_CYCLES - 1);
            WR_HOLD:  return CW'(WR_HOLD_CYCLES - 1);
            TURN:     return CW'(TURN_CYCLES - 1);
            default:  return '0;
        endcase
    endfunction

    assign last       = (cnt == '0);
    assign hold_last  = ((state == RD_HOLD) || (state == WR_HOLD)) && last;
    assign wb_stall_o = !((state == IDLE) || hold_last);
    assign accept     = wb_cycle_i && wb_strobe_i && !wb_stall_o;

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load_bus   = 1'b0;
        load_pend  = 1'b0;
        store_pend = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = wb_we_i ? WR_SETUP : RD_ACC;
                    load_bus  = 1'b1;
                end
            end
            RD_ACC:   if (last) state_nxt = RD_HOLD;
            WR_SETUP: if (last) state_nxt = WR_PULSE;
            WR_PULSE: if (last) state_nxt = WR_HOLD;
            RD_HOLD, WR_HOLD: begin
                if (last) begin
                    // Same direction chains straight on; anything else parks the bus in TURN.
                    if (accept && (wb_we_i == (state == WR_HOLD))) begin
                        state_nxt = wb_we_i ? WR_SETUP : RD_ACC;
                        load_bus  = 1'b1;
                    end else begin
                        state_nxt  = TURN;
                        store_pend = accept;
                    end
                end
            end
            TURN: begin
                if (last) begin
                    if (pend_vld && wb_cycle_i) begin
                        state_nxt = pend_we ? WR_SETUP : RD_ACC;
                        load_pend = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clock_i or negedge wb_reset_ni) begin
        if (!wb_reset_ni) begin
            cnt         <= '0;
            wb_ack_o    <= 1'b0;
            wb_data_o   <= '0;
            ram_oe_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_data_oe <= 1'b0;
            ram_addr_o  <= '0;
            ram_data_o  <= '0;
            abort       <= 1'b0;
            pend_vld    <= 1'b0;
            pend_we     <= 1'b0;
            pend_addr   <= '0;
            pend_dat    <= '0;
        end else begin
            if (state_nxt != state) begin
                cnt <= phase_len(state_nxt);
            end else if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end

            wb_ack_o <= hold_last && !abort && wb_cycle_i;

            if ((state == RD_ACC) && last) begin
                wb_data_o <= ram_data_i;
            end

            if (load_bus) begin
                ram_addr_o <= wb_addr_i;
                if (wb_we_i) ram_data_o <= wb_data_i;
            end else if (load_pend) begin
                ram_addr_o <= pend_addr;
                if (pend_we) ram_data_o <= pend_dat;
            end

            if (store_pend) begin
                pend_vld  <= 1'b1;
                pend_we   <= wb_we_i;
                pend_addr <= wb_addr_i;
                pend_dat  <= wb_data_i;
            end else if ((state == TURN) && (last || !wb_cycle_i)) begin
                pend_vld <= 1'b0;
            end

            // A dropped cycle only silences the ack; the SRAM phases still run to completion.
            if (accept) begin
                abort <= 1'b0;
            end else if ((state != IDLE) && !wb_cycle_i) begin
                abort <= 1'b1;
            end

            ram_oe_o    <= (state_nxt == RD_ACC) || (state_nxt == RD_HOLD);
            ram_we_o    <= (state_nxt == WR_PULSE);
            ram_data_oe <= (state_nxt == WR_SETUP) || (state_nxt == WR_PULSE) ||
                           (state_nxt == WR_HOLD);
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: a default-timing instance and an all-phases-one instance,
// each behind a small behavioural SRAM; expected acks are queued at issue and popped by a monitor.
module tb_sram_ctrl;
    localparam int AW = 17;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdat  [2];
    logic          we    [2];
    logic          cyc   [2];
    logic          stb   [2];
    logic [DW-1:0] rdat  [2];
    logic          stall [2];
    logic          ack   [2];
    logic          oe    [2];
    logic          rwe   [2];
    logic          doe   [2];
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] rdin  [2];
    logic [DW-1:0] rdout [2];

    sram_ctrl u_dut (
        .wb_clock_i(clk), .wb_reset_ni(rst_n), .wb_addr_i(addr[0]), .wb_data_i(wdat[0]),
        .wb_data_o(rdat[0]), .wb_we_i(we[0]), .wb_cycle_i(cyc[0]), .wb_strobe_i(stb[0]),
        .wb_stall_o(stall[0]), .wb_ack_o(ack[0]), .ram_oe_o(oe[0]), .ram_we_o(rwe[0]),
        .ram_addr_o(raddr[0]), .ram_data_i(rdin[0]), .ram_data_o(rdout[0]), .ram_data_oe(doe[0])
    );

    sram_ctrl #(
        .RD_CYCLES(1), .RD_HOLD_CYCLES(1), .WR_SETUP_CYCLES(1),
        .WR_PULSE_CYCLES(1), .WR_HOLD_CYCLES(1), .TURN_CYCLES(1)
    ) u_min (
        .wb_clock_i(clk), .wb_reset_ni(rst_n), .wb_addr_i(addr[1]), .wb_data_i(wdat[1]),
        .wb_data_o(rdat[1]), .wb_we_i(we[1]), .wb_cycle_i(cyc[1]), .wb_strobe_i(stb[1]),
        .wb_stall_o(stall[1]), .wb_ack_o(ack[1]), .ram_oe_o(oe[1]), .ram_we_o(rwe[1]),
        .ram_addr_o(raddr[1]), .ram_data_i(rdin[1]), .ram_data_o(rdout[1]), .ram_data_oe(doe[1])
    );

    // Behavioural SRAM per instance, preloadable from the stimulus thread.
    logic [DW-1:0] mem [2][1 << AW];
    logic          pl_vld;
    bit            pl_sel;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_dat;

    always @(posedge clk) begin
        if (pl_vld) mem[pl_sel][pl_addr] <= pl_dat;
        for (int d = 0; d < 2; d++) begin
            if (rwe[d]) mem[d][raddr[d]] <= rdout[d];
        end
    end

    assign rdin[0] = oe[0] ? mem[0][raddr[0]] : '0;
    assign rdin[1] = oe[1] ? mem[1][raddr[1]] : '0;

    int ecount = 0;
    always @(posedge clk) ecount <= ecount + 1;

    typedef struct {
        int            at;
        bit            rd;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;
    bit   win      = 1'b0;
    int   oe_low   = 0;
    logic          pwe   [2];
    logic [AW-1:0] paddr [2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ecount);
        end
    endtask

    // Monitor: invariants every clock, and scoreboard pop on every ack.
    always @(negedge clk) begin
        exp_t e;
        bit   got;
        for (int d = 0; d < 2; d++) begin
            if (rst_n) begin
                chk("oe_with_data_oe", int'(oe[d] & doe[d]), 0);
                chk("we_without_data_oe", int'(rwe[d] & ~doe[d]), 0);
                chk("addr_moved_under_we", int'(rwe[d] && pwe[d] && (raddr[d] != paddr[d])), 0);
                if (ack[d]) begin
                    got = 1'b0;
                    if (d == 0 && q0.size() != 0) begin e = q0.pop_front(); got = 1'b1; end
                    if (d == 1 && q1.size() != 0) begin e = q1.pop_front(); got = 1'b1; end
                    checks++;
                    if (!got) begin
                        failures++;
                        $display("FAIL unexpected_ack: dut%0d acked at edge %0d, expected no ack", d, ecount);
                    end else begin
                        chk(d == 0 ? "ack_edge" : "min_ack_edge", ecount, e.at);
                        if (e.rd) chk(d == 0 ? "read_data" : "min_read_data", int'(rdat[d]), int'(e.dat));
                    end
                end
            end
            pwe[d]   <= rwe[d];
            paddr[d] <= raddr[d];
        end
        if (win && !oe[0]) oe_low <= oe_low + 1;
    end

    task automatic next_clk;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input bit d, input logic [AW-1:0] a, input logic [DW-1:0] v);
        pl_sel = d; pl_addr = a; pl_dat = v; pl_vld = 1'b1;
        next_clk();
        pl_vld = 1'b0;
    endtask

    // Issue one request; call at posedge+1. Returns just after the accepting edge.
    task automatic wb_req(input int d, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] dt,
                          input int lat, input bit exp_ack, input logic [DW-1:0] exp_d,
                          output int acc);
        int n = 0;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; addr[d] = a; wdat[d] = dt;
        @(negedge clk);
        while (stall[d] && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (stall[d]) begin
            checks++; failures++;
            $display("FAIL accept_timeout: dut%0d still stalled after %0d clocks, expected accept", d, n);
        end
        acc = ecount + 1;
        if (exp_ack) begin
            if (d == 0) q0.push_back('{acc + lat, !w, exp_d});
            else        q1.push_back('{acc + lat, !w, exp_d});
        end
        next_clk();
        stb[d] = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while ((q0.size() + q1.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("outstanding_acks", q0.size() + q1.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, n_oe, n_st, n_we, n_doe, bad, first_we, last_we;
        rst_n = 1'b0;
        pl_vld = 1'b0; pl_sel = 1'b0; pl_addr = '0; pl_dat = '0;
        for (int d = 0; d < 2; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdat[d] = '0;
        end
        next_clk();
        preload(0, 17'h1ABCD, 8'h5A);
        preload(0, 17'h00100, 8'h11);
        preload(0, 17'h00101, 8'h22);
        preload(0, 17'h00102, 8'h33);
        preload(0, 17'h00020, 8'h99);
        preload(0, 17'h00040, 8'h00);
        preload(1, 17'h00005, 8'hA7);

        // Reset values
        @(negedge clk);
        chk("rst_stall", int'(stall[0]), 0);
        chk("rst_ack", int'(ack[0]), 0);
        chk("rst_oe", int'(oe[0]), 0);
        chk("rst_we", int'(rwe[0]), 0);
        chk("rst_data_oe", int'(doe[0]), 0);
        chk("rst_addr", int'(raddr[0]), 0);
        chk("rst_ram_dout", int'(rdout[0]), 0);
        chk("rst_wb_dout", int'(rdat[0]), 0);
        next_clk();
        rst_n = 1'b1;
        next_clk();

        // Single read
        wb_req(0, 1'b0, 17'h1ABCD, 8'h00, 7, 1'b1, 8'h5A, a0);
        n_oe = 0; n_st = 0; bad = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i <= 7) begin
                n_oe += int'(oe[0]);
                n_st += int'(stall[0]);
            end else if (i <= 9) begin
                bad += int'(oe[0] | doe[0]);
            end
        end
        chk("rd_oe_clocks", n_oe, 7);
        chk("rd_stall_clocks", n_st, 6);
        chk("rd_turn_bus_idle", bad, 0);
        chk("rd_idle_stall", int'(stall[0]), 0);
        next_clk();

        // Single write
        wb_req(0, 1'b1, 17'h00010, 8'hC3, 9, 1'b1, 8'h00, a0);
        n_doe = 0; n_we = 0; n_oe = 0; bad = 0; first_we = 0; last_we = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i <= 9) n_doe += int'(doe[0]);
            if (rwe[0]) begin
                n_we++;
                if (first_we == 0) first_we = i;
                last_we = i;
            end
            if (i == 10 || i == 11) bad += int'(doe[0] | rwe[0] | oe[0]);
            n_oe += int'(oe[0]);
        end
        chk("wr_data_oe_clocks", n_doe, 9);
        chk("wr_we_clocks", n_we, 5);
        chk("wr_we_first", first_we, 3);
        chk("wr_we_last", last_we, 7);
        chk("wr_turn_bus_idle", bad, 0);
        chk("wr_no_oe", n_oe, 0);
        next_clk();

        // Read chain: OE held continuously across three pipelined reads
        wb_req(0, 1'b0, 17'h00100, 8'h00, 7, 1'b1, 8'h11, a0);
        win = 1'b1;
        wb_req(0, 1'b0, 17'h00101, 8'h00, 7, 1'b1, 8'h22, a1);
        wb_req(0, 1'b0, 17'h00102, 8'h00, 7, 1'b1, 8'h33, a2);
        repeat (7) @(negedge clk);
        #1 win = 1'b0;
        chk("chain_gap_1", a1 - a0, 7);
        chk("chain_gap_2", a2 - a1, 7);
        chk("chain_oe_low_clocks", oe_low, 0);
        drain();

        // Direction change: read, write same address, read back
        wb_req(0, 1'b0, 17'h00020, 8'h00, 7, 1'b1, 8'h99, a0);
        wb_req(0, 1'b1, 17'h00020, 8'h77, 11, 1'b1, 8'h00, a1);
        chk("dir_wr_accept", a1 - a0, 7);
        bad = 0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            bad += int'(oe[0] | doe[0]);
        end
        chk("dir_turn_bus_idle", bad, 0);
        @(negedge clk);
        chk("dir_wr_data_oe", int'(doe[0]), 1);
        next_clk();
        wb_req(0, 1'b0, 17'h00020, 8'h00, 9, 1'b1, 8'h77, a2);
        chk("dir_rb_accept", a2 - a1, 11);
        drain();

        // Abort: cycle drops on the second WE-pulse clock
        wb_req(0, 1'b1, 17'h00040, 8'h55, 0, 1'b0, 8'h00, a0);
        n_we = 0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 4) cyc[0] = 1'b0;
            @(negedge clk);
            n_we += int'(rwe[0]);
            next_clk();
        end
        chk("abort_we_clocks", n_we, 5);
        wb_req(0, 1'b0, 17'h00040, 8'h00, 7, 1'b1, 8'h55, a0);
        drain();

        // Reset in the middle of a WE pulse
        wb_req(0, 1'b1, 17'h00050, 8'hEE, 0, 1'b0, 8'h00, a0);
        repeat (3) next_clk();
        @(negedge clk);
        chk("prerst_we", int'(rwe[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_we", int'(rwe[0]), 0);
        chk("midrst_data_oe", int'(doe[0]), 0);
        chk("midrst_ack", int'(ack[0]), 0);
        chk("midrst_stall", int'(stall[0]), 0);
        repeat (2) next_clk();
        rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_stall", int'(stall[0]), 0);
        next_clk();
        wb_req(0, 1'b0, 17'h1ABCD, 8'h00, 7, 1'b1, 8'h5A, a0);
        drain();

        // All phases one clock
        wb_req(1, 1'b0, 17'h00005, 8'h00, 2, 1'b1, 8'hA7, a0);
        wb_req(1, 1'b1, 17'h00006, 8'h3C, 4, 1'b1, 8'h00, a1);
        chk("min_wr_accept", a1 - a0, 2);
        wb_req(1, 1'b0, 17'h00006, 8'h00, 3, 1'b1, 8'h3C, a2);
        chk("min_rb_accept", a2 - a1, 4);
        wb_req(1, 1'b0, 17'h00005, 8'h00, 2, 1'b1, 8'hA7, a0);
        chk("min_chain_accept", a0 - a2, 3);
        wb_req(1, 1'b0, 17'h00006, 8'h00, 2, 1'b1, 8'h3C, a1);
        chk("min_chain_gap", a1 - a0, 2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
